fifo_write_arbiter: RTL

//   Shares the single write port of one Fifo (SIZE-bit data, LEN deep) between N requesters.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_write_arbiter_picker.sv | 42 ++++
 rtl/fifo_write_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the Fifo write-port arbiter.
//   arb_state_t : arbiter state (IDLE while choosing an owner, LOCKED while an owner holds the port)
//   idx_width() : width of an index into N requesters (at least 1 bit)
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Round-robin priority picker, purely combinational.
// Scans the request vector starting at ptr and wrapping modulo N. It returns
// the first requester found.
//   req   in   N    request bits
//   ptr   in   IW   index that has the highest priority
//   found out  1    at least one request bit is set
//   idx   out  IW   index of the winner (0 when nothing is found)
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // cand_idx[k] is the requester that sits k places after ptr.
    logic [IW-1:0] cand_idx [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign cand_idx[gi] = IW'((int'(ptr) + gi) % N);
        end
    endgenerate

    // The scan runs from the farthest candidate to the nearest one.
    // The last hit is therefore the candidate closest to ptr.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                found = 1'b1;
                idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the write port of one Fifo between N requesters.
// A grant covers one burst. An owner keeps the grant until its last beat,
// or until MAX_BURST beats have transferred. The next owner is chosen by
// round robin, starting after the previous owner.
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active low
//   req_valid_i  in   N       per-requester beat valid
//   req_data_i   in   N*SIZE  per-requester data, slice i at [i*SIZE +: SIZE]
//   req_last_i   in   N       per-requester end-of-burst marker
//   req_ready_o  out  N       beat of requester i accepted (at most one bit set)
//   fifo_valid_o out  1       Fifo write strobe
//   fifo_data_o  out  SIZE    Fifo write data
//   fifo_full_i  in   1       Fifo full flag
//   grant_o      out  N       one-hot owner, 0 when idle
//   grant_idx_o  out  IW      owner index, 0 when idle
//   busy_o       out  1       an owner holds the port
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int SIZE      = 32,
    parameter int MAX_BURST = 8,
    localparam int IW = idx_width(N),
    localparam int CW = $clog2(MAX_BURST) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_valid_i,
    input  logic [N*SIZE-1:0] req_data_i,
    input  logic [N-1:0]    req_last_i,
    output logic [N-1:0]    req_ready_o,
    output logic            fifo_valid_o,
    output logic [SIZE-1:0] fifo_data_o,
    input  logic            fifo_full_i,
    output logic [N-1:0]    grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            busy_o
);

    arb_state_t    state_reg;
    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] grant_idx_reg;
    logic [CW-1:0] beat_cnt_reg;

    logic [SIZE-1:0] req_slice [N];
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            locked;
    logic            xfer;
    logic            at_limit;
    logic [IW-1:0]   next_ptr;

    rr_priority_picker #(.N(N)) u_picker (
        .req   (req_valid_i),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_port
            assign req_slice[gi]   = req_data_i[gi*SIZE +: SIZE];
            assign grant_o[gi]     = locked & (grant_idx_reg == IW'(gi));
            // Only the owner sees ready. Ready is held low while the Fifo is full.
            assign req_ready_o[gi] = grant_o[gi] & ~fifo_full_i;
        end
    endgenerate

    assign locked   = (state_reg == LOCKED);
    assign xfer     = locked & req_valid_i[grant_idx_reg] & ~fifo_full_i;
    assign at_limit = (beat_cnt_reg == CW'(MAX_BURST - 1));
    assign next_ptr = (grant_idx_reg == IW'(N - 1)) ? '0 : grant_idx_reg + IW'(1);

    assign busy_o       = locked;
    assign fifo_valid_o = xfer;
    assign fifo_data_o  = locked ? req_slice[grant_idx_reg] : '0;
    assign grant_idx_o  = locked ? grant_idx_reg : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
            beat_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Arbitration takes one cycle. The port stays idle during it.
                    if (pick_found) begin
                        state_reg     <= LOCKED;
                        grant_idx_reg <= pick_idx;
                        beat_cnt_reg  <= '0;
                    end
                end
                LOCKED: begin
                    // The owner can pause mid-burst and keep its grant.
                    // The grant ends only on a beat that actually transfers.
                    if (xfer) begin
                        if (req_last_i[grant_idx_reg] || at_limit) begin
                            state_reg    <= IDLE;
                            rr_ptr_reg   <= next_ptr;
                            beat_cnt_reg <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + CW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
